// File: rtl/wb_pkg.sv
// Shared opcode constants, entry classes and the retirement decode for the write-back stage.
package wb_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_LH    = 6'b100001;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  typedef enum logic [2:0] {
    CLS_WRITE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_LINK,
    CLS_NONE,
    CLS_ILLEGAL
  } cls_e;

  typedef struct packed {
    logic we;
    logic redirect;
    logic link;
    logic illegal;
  } dec_t;

  function automatic cls_e op_class(input logic [OP_W-1:0] op);
    cls_e c;
    case (op)
      OP_RTYPE, OP_ADDI, OP_LW, OP_LH: c = CLS_WRITE;
      OP_BEQ, OP_BNE:                  c = CLS_BRANCH;
      OP_J:                            c = CLS_JUMP;
      OP_JAL:                          c = CLS_LINK;
      OP_SW:                           c = CLS_NONE;
      default:                         c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

  // Branch direction is resolved here from the stored compare result.
  function automatic dec_t decode(input logic [OP_W-1:0] op, input logic cond);
    dec_t d;
    d = '0;
    case (op_class(op))
      CLS_WRITE:   d.we = 1'b1;
      CLS_BRANCH:  d.redirect = (op == OP_BEQ) ? cond : !cond;
      CLS_JUMP:    d.redirect = 1'b1;
      CLS_LINK: begin
        d.we       = 1'b1;
        d.redirect = 1'b1;
        d.link     = 1'b1;
      end
      CLS_ILLEGAL: d.illegal = 1'b1;
      default:     d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/wb_queue_if.sv
// Producer-side enqueue bus plus the retirement outputs of the write-back queue.
interface wb_queue_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned DEPTH = 4
);
  import wb_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_op;
  logic            in_cond;
  logic [RA_W-1:0] in_rd;
  logic [XLEN-1:0] in_data;
  logic [XLEN-1:0] in_target;
  logic            stall;
  logic            reg_we;
  logic [RA_W-1:0] reg_waddr;
  logic [XLEN-1:0] reg_wdata;
  logic            pc_update;
  logic [XLEN-1:0] pc_new;
  logic            illegal;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, in_op, in_cond, in_rd, in_data, in_target, stall,
    input  in_ready, reg_we, reg_waddr, reg_wdata, pc_update, pc_new, illegal, count
  );

  modport slave (
    input  in_valid, in_op, in_cond, in_rd, in_data, in_target, stall,
    output in_ready, reg_we, reg_waddr, reg_wdata, pc_update, pc_new, illegal, count
  );

endinterface

// File: rtl/wb_fifo.sv
// Opcode-agnostic in-order storage with push, pop, flush and occupancy count.
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally; occupancy alone decides full/empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back stage: buffers completed results and retires one per cycle to the RF / PC.
module wb_queue
  import wb_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RA_W     = 5,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned LINK_REG = 31
) (
  input  logic   clk,
  input  logic   rst,
  wb_queue_if.slave bus
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = OP_W + 1 + RA_W + 2 * XLEN;

  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   occ;
  logic               full;
  logic               empty;
  logic               push;
  logic               retire;
  logic               flush;

  logic [OP_W-1:0]    h_op;
  logic               h_cond;
  logic [RA_W-1:0]    h_rd;
  logic [XLEN-1:0]    h_data;
  logic [XLEN-1:0]    h_target;
  dec_t               dec;
  logic [RA_W-1:0]    dest;

  assign wr_entry = {bus.in_op, bus.in_cond, bus.in_rd, bus.in_data, bus.in_target};
  assign {h_op, h_cond, h_rd, h_data, h_target} = head;

  assign bus.in_ready = !full;
  assign bus.count    = occ;
  assign push         = bus.in_valid && !full;
  assign retire       = !empty && !bus.stall;
  assign dec          = decode(h_op, h_cond);
  assign dest         = dec.link ? RA_W'(LINK_REG) : h_rd;
  // A taken redirect drops the head's younger entries and any same-cycle enqueue.
  assign flush        = retire && dec.redirect;

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (retire),
    .flush (flush),
    .wdata (wr_entry),
    .rdata (head),
    .count (occ),
    .full  (full),
    .empty (empty)
  );

  // Registered retirement outputs; strobes pulse for exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.reg_we    <= 1'b0;
      bus.reg_waddr <= '0;
      bus.reg_wdata <= '0;
      bus.pc_update <= 1'b0;
      bus.pc_new    <= '0;
      bus.illegal   <= 1'b0;
    end else begin
      bus.reg_we    <= 1'b0;
      bus.pc_update <= 1'b0;
      bus.illegal   <= 1'b0;
      if (retire) begin
        bus.reg_we    <= dec.we && (dest != '0);
        bus.reg_waddr <= dest;
        bus.reg_wdata <= h_data;
        bus.pc_update <= dec.redirect;
        bus.pc_new    <= h_target;
        bus.illegal   <= dec.illegal;
      end
    end
  end

endmodule

// File: doc/wb_queue.md
# wb_queue

Parametrised write-back stage for the multi-cycle CPU. It buffers completed results from execute/memory in a small in-order queue and retires one entry per cycle. Retiring an entry produces either a register-file write, a PC redirect, or both. A taken redirect flushes younger queued entries, so no wrong-path result ever reaches the register file.

## Interface
Parameters:
- XLEN, 32, data and PC width
- RA_W, 5, register address width
- DEPTH, 4, queue entries; power of two, ≥ 2
- LINK_REG, 31, destination register written by JAL

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  entry offered
- in_ready  out  1  queue can accept; equals !full
- in_op  in  6  opcode of completed instruction
- in_cond  in  1  branch compare result (1 = operands equal)
- in_rd  in  RA_W  destination register
- in_data  in  XLEN  result, or link value (PC+4) for JAL
- in_target  in  XLEN  branch/jump target
- stall  in  1  register file busy; hold retirement
- reg_we  out  1  register write strobe
- reg_waddr  out  RA_W  write address
- reg_wdata  out  XLEN  write data
- pc_update  out  1  redirect strobe
- pc_new  out  XLEN  redirect target
- illegal  out  1  retired entry had an unknown opcode
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Entry classes are decoded at retirement from in_op:
  - WRITE (rd): 000000 R-type, 001000 ADDI, 100011 LW, 100001 LH.
  - BRANCH: 000100 BEQ (taken if cond), 000101 BNE (taken if !cond).
  - JUMP: 000010 J.
  - LINK: 000011 JAL (write LINK_REG and redirect).
  - NONE: 101011 SW.
  - Any other opcode: illegal, no effect.
- Enqueue occurs when in_valid && in_ready. The queue stores {op, cond, rd, data, target}.
- Retirement happens each cycle when the queue is non-empty and !stall. The head entry is popped.
- Register write rule: reg_we=1 for WRITE and LINK. It is suppressed when the destination is register 0, for every class.
- Redirect rule: pc_update=1 for taken BRANCH, JUMP, and LINK; pc_new = target.
- On redirect, every entry behind the head is discarded and count goes to 0 on the next cycle. A same-cycle enqueue is also discarded.
- Not-taken branches, SW, and illegal entries only pop.
- Simultaneous enqueue and retire when full: in_ready is 0 when full, so no enqueue occurs that cycle.

## Timing
- All outputs are registered. reg_we, pc_update and illegal are single-cycle pulses.
- Latency: an entry enqueued at edge N into an empty, unstalled queue retires at edge N+1. Its strobes are visible in the cycle after edge N+1.
- Throughput: one retirement per cycle.
- stall=1: the head is held and no strobes are issued. Enqueue continues until full.
- count updates on the same edge as the push/pop. in_ready derives combinationally from count.
- Reset (asynchronous, any time, including mid-drain):
  - Queue empties; count=0; in_ready=1.
  - reg_we, pc_update, illegal = 0.
  - reg_waddr, reg_wdata, pc_new = 0.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty is resolved by count, not by pointer compare.

## Structure
- Package wb_pkg: opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_LH, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_SW), the entry-class enum, and a decode function op+cond → {we, redirect, link, illegal}.
- Sub-module wb_fifo: a parametrised DEPTH×width storage with push, pop, flush, and count. It has no knowledge of opcodes.
- The top level holds the decode and the registered output stage.

## Test plan
- Reset mid-drain: queue three entries, assert rst after the first retirement. Required: count=0, no further strobes, in_ready=1, outputs zero.
- Single write: in_op=000000, rd=5, data=32'h2343_9870 into an empty queue. Required: one cycle later reg_we=1, waddr=5, wdata=32'h2343_9870, pc_update=0.
- Back-to-back fill with stall=1: push 4 entries. Required: count=4, in_ready=0, fifth offer not accepted. Release stall: four consecutive retirements in order, count 3,2,1,0.
- BEQ taken flush: push BEQ (cond=1, target=32'h0000_0040), then ADDI rd=7, then LW rd=8. Required: pc_update=1 with pc_new=32'h40, no writes to 7 or 8, count=0 afterward. Repeat with cond=0: no redirect, both writes occur.
- JAL: push op=000011, data=32'h0000_1004, target=32'h0000_2000. Required: same cycle reg_we=1, waddr=31, wdata=32'h1004, pc_update=1, pc_new=32'h2000.
- Register 0 and illegal entries: push ADDI with rd=0. Required: no reg_we. Push op=111111. Required: illegal=1 for one cycle and nothing else asserted.
